expr_field_unpacker: RTL and testbench
======================================

# expr_field_unpacker

Reader for the 90-bit packed expression result bus produced by the vloghammer expression blocks. It accepts one packed word over a valid/ready handshake and streams the 18 fields y0..y17 out one per beat. Each field is zero- or sign-extended to 8 bits according to its declared type. It sits between a DUT expression block and the regression scoreboard, so results can be compared field by field.

## Interface
Parameters:
- OUT_W, 8, width of extended output field; must be ≥ 6
- CNT_W, 16, width of the accepted-word counter

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  packed word available
- in_ready  out  1  block can accept a word
- in_data  in  90  packed word {y0,...,y17}; y0 at bits 89:86
- out_valid  out  1  field beat valid
- out_ready  in  1  sink accepts beat
- out_data  out  OUT_W  extended field value
- out_idx  out  5  field index 0..17 (18 for checksum beat)
- out_last  out  1  final beat of the word
- word_cnt  out  CNT_W  number of words fully streamed; wraps

## Operation
- Field map, for i = 0..17:
  - width = 4 + (i mod 3)
  - signed when (i mod 6) ≥ 3
  - MSB = 89 − 15·(i/3) − {0,4,9}[i mod 3]
- Extension: signed fields replicate their MSB up to OUT_W bits; unsigned fields are zero-filled.
- FSM states:
  - IDLE: in_ready=1, out_valid=0. When in_valid && in_ready, capture in_data, set idx=0, go to SEND.
  - SEND: out_valid=1, out_data/out_idx show field idx. On out_valid && out_ready: if idx=17, go to IDLE (or CSUM when the macro is defined) and increment word_cnt; otherwise idx++.
  - CSUM (macro only): see Configuration.
- in_ready is decoded from state == IDLE. No word is accepted while streaming.
- While out_valid && !out_ready, out_data, out_idx and out_last are held stable.
- out_last=1 only on the final beat: idx 17 without the macro, idx 18 with it.
- word_cnt wraps from 2^CNT_W−1 to 0.
- in_data is ignored outside IDLE. A captured word is unaffected by later in_data changes.

## Timing
- Reset (asynchronous, while rst_n=0): state=IDLE, so in_ready=1; out_valid=0, out_data=0, out_idx=0, out_last=0, word_cnt=0.
- Latency: a word accepted in cycle N presents field 0 in cycle N+1.
- Throughput: one beat per cycle under continuous out_ready. There is a 1-cycle IDLE bubble between words, giving 19 cycles per word (20 with the macro).
- word_cnt updates in the cycle after the last beat's handshake.
- Reset asserted mid-word aborts the word: no partial count, and streaming does not resume.
- Reset release is synchronized by the top level; the block only requires rst_n to be asynchronous.

## Configuration
- EXPR_UNPACK_CHECKSUM_EN defined:
  - A running XOR of all 18 extended out_data values is kept.
  - After the idx-17 handshake, the FSM enters CSUM and emits one extra beat: out_idx=18, out_data=XOR, out_last=1.
  - word_cnt increments on the CSUM handshake instead of the idx-17 handshake.
  - The accumulator clears on word accept.
- Not defined: no CSUM state or accumulator logic; the idx-17 beat carries out_last.

## Structure
- Package expr_unpack_pkg holds:
  - NUM_FIELDS=18 and IN_W=90
  - functions field_width(i), field_signed(i) and field_msb(i)
  - the state enum (IDLE, SEND, CSUM)
- One sub-module, expr_field_extract: purely combinational. Takes the 90-bit word and a 5-bit index and returns the OUT_W extended value.
- The top module holds the FSM, the capture register, the index counter, word_cnt and the optional checksum accumulator.

## Test plan
- Reset, then idle: in_ready=1, out_valid=0, word_cnt=0.
- Word with y0=4'hF, y3=4'b1000, y5=6'b100000 and all other fields 0, with out_ready=1:
  - out_data sequence starts 0x0F, 0x00, 0x00, 0xF8, 0x00, 0xE0, followed by twelve 0x00 beats.
  - out_last is set on idx 17; word_cnt=1.
- All-ones word:
  - Unsigned fields give 0x0F / 0x1F / 0x3F; signed fields give 0xFF.
  - With EXPR_UNPACK_CHECKSUM_EN, the idx-18 beat carries 0xD0 with out_last=1.
- Random out_ready backpressure (50%): beats stay stable while stalled, no beat is lost or duplicated, and in_ready stays 0 until the final handshake.
- rst_n pulsed low at beat idx 7: outputs return to reset values immediately, word_cnt stays unchanged, and the next accepted word streams from idx 0.
- Back-to-back words with in_valid held high: second accept happens exactly 1 cycle after the last handshake; set word_cnt to 16'hFFFF first and confirm it wraps to 0.

Source files
------------

// File: rtl/expr_unpack_pkg.sv
// rtl/expr_unpack_pkg.sv - field map, sizes and state type for the packed expression result unpacker
package expr_unpack_pkg;

  localparam int NUM_FIELDS = 18;
  localparam int IN_W       = 90;
  localparam int LAST_IDX   = NUM_FIELDS - 1;
  localparam int CSUM_IDX   = NUM_FIELDS;

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    CSUM
  } state_t;

  // Fields come in groups of three (4, 5, 6 bits wide), 15 bits per group.
  function automatic int field_width(input int i);
    return 4 + (i % 3);
  endfunction

  function automatic logic field_signed(input int i);
    return (i % 6) >= 3;
  endfunction

  function automatic int field_msb(input int i);
    int off;
    case (i % 3)
      0:       off = 0;
      1:       off = 4;
      default: off = 9;
    endcase
    return 89 - 15 * (i / 3) - off;
  endfunction

endpackage

// File: rtl/expr_field_unpacker_if.sv
// rtl/expr_field_unpacker_if.sv - packed word input and field beat output handshakes
interface expr_field_unpacker_if #(
  parameter int OUT_W = 8
);
  import expr_unpack_pkg::*;

  logic             in_valid;
  logic             in_ready;
  logic [IN_W-1:0]  in_data;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] out_data;
  logic [4:0]       out_idx;
  logic             out_last;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_idx, out_last
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_idx, out_last
  );

endinterface

// File: rtl/expr_field_extract.sv
// rtl/expr_field_extract.sv - combinational select and zero/sign extension of one field of the packed word
module expr_field_extract
  import expr_unpack_pkg::*;
#(
  parameter int OUT_W = 8
) (
  input  logic [IN_W-1:0]  word,
  input  logic [4:0]       idx,
  output logic [OUT_W-1:0] value
);

  logic [IN_W-1:0] shifted;
  logic            sign;
  int              w;

  always_comb begin
    shifted = '0;
    sign    = 1'b0;
    w       = 4;
    value   = '0;
    for (int i = 0; i < NUM_FIELDS; i++) begin
      if (idx == 5'(i)) begin
        w       = field_width(i);
        shifted = word >> (field_msb(i) - w + 1);
        sign    = field_signed(i) && shifted[7'(w - 1)];
      end
    end
    // Bits above the field width take the sign (zero for unsigned fields).
    for (int b = 0; b < OUT_W; b++) begin
      value[b] = (b < w) ? shifted[b] : sign;
    end
  end

endmodule

// File: rtl/expr_field_unpacker.sv
// rtl/expr_field_unpacker.sv - streams the 18 fields of a 90-bit result word one per beat; EXPR_UNPACK_CHECKSUM_EN adds an XOR checksum beat
module expr_field_unpacker
  import expr_unpack_pkg::*;
#(
  parameter int OUT_W = 8,
  parameter int CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  expr_field_unpacker_if.slave bus,
  output logic [CNT_W-1:0]     word_cnt
);

  state_t           state_q, state_d;
  logic [IN_W-1:0]  word_q, word_d;
  logic [4:0]       idx_q, idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [OUT_W-1:0] field;
`ifdef EXPR_UNPACK_CHECKSUM_EN
  logic [OUT_W-1:0] csum_q, csum_d;
`endif

  expr_field_extract #(.OUT_W(OUT_W)) u_extract (
    .word  (word_q),
    .idx   (idx_q),
    .value (field)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      word_q  <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
`ifdef EXPR_UNPACK_CHECKSUM_EN
      csum_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
`ifdef EXPR_UNPACK_CHECKSUM_EN
      csum_q  <= csum_d;
`endif
    end
  end

  always_comb begin
    state_d       = state_q;
    word_d        = word_q;
    idx_d         = idx_q;
    cnt_d         = cnt_q;
`ifdef EXPR_UNPACK_CHECKSUM_EN
    csum_d        = csum_q;
`endif
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    bus.out_data  = '0;
    bus.out_idx   = '0;
    bus.out_last  = 1'b0;
    case (state_q)
      IDLE: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) begin
          word_d  = bus.in_data;
          idx_d   = '0;
`ifdef EXPR_UNPACK_CHECKSUM_EN
          csum_d  = '0;
`endif
          state_d = SEND;
        end
      end
      SEND: begin
        bus.out_valid = 1'b1;
        bus.out_data  = field;
        bus.out_idx   = idx_q;
`ifndef EXPR_UNPACK_CHECKSUM_EN
        bus.out_last  = (idx_q == 5'(LAST_IDX));
`endif
        if (bus.out_ready) begin
`ifdef EXPR_UNPACK_CHECKSUM_EN
          csum_d = csum_q ^ field;
`endif
          if (idx_q == 5'(LAST_IDX)) begin
`ifdef EXPR_UNPACK_CHECKSUM_EN
            state_d = CSUM;
`else
            state_d = IDLE;
            cnt_d   = cnt_q + CNT_W'(1);
`endif
          end else begin
            idx_d = idx_q + 5'd1;
          end
        end
      end
`ifdef EXPR_UNPACK_CHECKSUM_EN
      CSUM: begin
        bus.out_valid = 1'b1;
        bus.out_data  = csum_q;
        bus.out_idx   = 5'(CSUM_IDX);
        bus.out_last  = 1'b1;
        if (bus.out_ready) begin
          state_d = IDLE;
          cnt_d   = cnt_q + CNT_W'(1);
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  assign word_cnt = cnt_q;

endmodule

// File: tb/tb_expr_field_unpacker.sv
// tb/tb_expr_field_unpacker.sv - self-checking bench for expr_field_unpacker
module tb_expr_field_unpacker;

  localparam int CW = 4;
`ifdef EXPR_UNPACK_CHECKSUM_EN
  localparam int NB = 19;
`else
  localparam int NB = 18;
`endif

  typedef struct packed {
    logic [89:0]      word;
    logic [17:0][7:0] exp;
    logic [7:0]       csum;
  } vec_t;

  logic          clk;
  logic          rst_n;
  logic [CW-1:0] word_cnt;
  int            checks;
  int            errors;
  int            exp_cnt;
  vec_t          vecs [3];

  expr_field_unpacker_if #(.OUT_W(8)) bus ();

  expr_field_unpacker #(.OUT_W(8), .CNT_W(CW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus),
    .word_cnt (word_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // Reference field value from the field map using signed integer arithmetic.
  function automatic logic [7:0] ref_field(input logic [89:0] w, input int i);
    int          wd;
    int          msb;
    int          v;
    logic [89:0] t;
    wd  = 4 + i % 3;
    msb = 89 - 15 * (i / 3) - ((i % 3 == 0) ? 0 : (i % 3 == 1) ? 4 : 9);
    t   = w >> (msb - wd + 1);
    v   = int'(t[5:0]) % (1 << wd);
    if ((i % 6) >= 3 && v >= (1 << (wd - 1))) v = v - (1 << wd);
    return 8'(v);
  endfunction

  function automatic logic [89:0] rand_word();
    return 90'({$urandom(), $urandom(), $urandom()});
  endfunction

  task automatic stream_word(input logic [89:0] w, input logic [17:0][7:0] exp, input logic [7:0] cs,
                             input int rdy_pct, input bit hold, input logic [89:0] nxt);
    int         n;
    int         beat;
    logic [7:0] ed;
    bus.in_valid = 1'b1;
    bus.in_data  = w;
    n = 0;
    while (!bus.in_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    chk("accept_wait", 32'(n < 50), 32'd1);
    @(posedge clk); #1;
    if (hold) bus.in_data = nxt;
    else begin
      bus.in_valid = 1'b0;
      bus.in_data  = rand_word();
    end
    chk("first_beat", 32'({bus.out_valid, bus.out_idx}), 32'({1'b1, 5'd0}));
    beat = 0;
    n    = 0;
    while (beat < NB && n < 600) begin
      bus.out_ready = ($urandom_range(99) < rdy_pct);
      ed = (beat < 18) ? exp[beat] : cs;
      chk($sformatf("beat%0d", beat), 32'({bus.out_valid, bus.out_last, bus.out_idx, bus.out_data}),
          32'({1'b1, beat == NB - 1, 5'(beat), ed}));
      chk("in_ready_busy", 32'(bus.in_ready), 32'd0);
      if (bus.out_valid && bus.out_ready) beat++;
      @(posedge clk); #1;
      n++;
    end
    chk("beat_count", 32'(beat), 32'(NB));
    bus.out_ready = 1'b0;
    exp_cnt = (exp_cnt + 1) % (1 << CW);
    chk("word_cnt", 32'(word_cnt), 32'(exp_cnt));
    chk("idle_after", 32'({bus.in_ready, bus.out_valid}), 32'b10);
  endtask

  initial begin
    logic [89:0]      w;
    logic [89:0]      w2;
    logic [89:0]      w3;
    logic [17:0][7:0] e;
    logic [7:0]       cs;
    int               n;

    checks = 0;
    errors = 0;
    exp_cnt = 0;

    vecs[0].word = '0;
    vecs[0].word[89:86] = 4'hF;
    vecs[0].word[74:71] = 4'b1000;
    vecs[0].word[65:60] = 6'b100000;
    vecs[0].exp = '0;
    vecs[0].exp[0] = 8'h0F;
    vecs[0].exp[3] = 8'hF8;
    vecs[0].exp[5] = 8'hE0;
    vecs[0].csum = 8'h17;
    vecs[1].word = '1;
    for (int i = 0; i < 18; i++) begin
      vecs[1].exp[i] = ((i % 6) >= 3) ? 8'hFF : (i % 3 == 0) ? 8'h0F : (i % 3 == 1) ? 8'h1F : 8'h3F;
    end
    vecs[1].csum = 8'hD0;
    vecs[2].word = '0;
    vecs[2].exp  = '0;
    vecs[2].csum = 8'h00;

    rst_n = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_out_data", 32'(bus.out_data), 32'd0);
    chk("rst_out_idx", 32'(bus.out_idx), 32'd0);
    chk("rst_out_last", 32'(bus.out_last), 32'd0);
    chk("rst_word_cnt", 32'(word_cnt), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("idle_state", 32'({bus.in_ready, bus.out_valid, word_cnt}), 32'({1'b1, 1'b0, CW'(0)}));

    // Reset pulsed while beat 7 is on the bus aborts the word.
    bus.in_valid = 1'b1;
    bus.in_data  = '1;
    @(posedge clk); #1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    n = 0;
    while (!(bus.out_valid && bus.out_idx == 5'd7) && n < 30) begin
      @(posedge clk); #1;
      n++;
    end
    chk("reach_idx7", 32'(n < 30), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_outputs", 32'({bus.in_ready, bus.out_valid, bus.out_last, bus.out_idx, bus.out_data}),
        32'({1'b1, 1'b0, 1'b0, 5'd0, 8'd0}));
    chk("async_rst_cnt", 32'(word_cnt), 32'(exp_cnt));
    @(posedge clk); #3;
    rst_n = 1'b1;
    bus.out_ready = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
      chk("no_resume", 32'({bus.in_ready, bus.out_valid, word_cnt}), 32'({1'b1, 1'b0, CW'(exp_cnt)}));
    end

    for (int v = 0; v < 3; v++) begin
      stream_word(vecs[v].word, vecs[v].exp, vecs[v].csum, 100, 1'b0, '0);
    end

    for (int k = 0; k < 11; k++) begin
      w  = rand_word();
      cs = '0;
      for (int i = 0; i < 18; i++) begin
        e[i] = ref_field(w, i);
        cs   = cs ^ e[i];
      end
      stream_word(w, e, cs, 50, 1'b0, '0);
    end

    // Back-to-back words with in_valid held high; the count wraps on the second.
    w  = rand_word();
    w2 = rand_word();
    w3 = rand_word();
    for (int k = 0; k < 3; k++) begin
      logic [89:0] cur;
      logic [89:0] nxt;
      cur = (k == 0) ? w : (k == 1) ? w2 : w3;
      nxt = (k == 0) ? w2 : w3;
      cs  = '0;
      for (int i = 0; i < 18; i++) begin
        e[i] = ref_field(cur, i);
        cs   = cs ^ e[i];
      end
      stream_word(cur, e, cs, 100, k < 2, nxt);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
